// File: rtl/alu_exec_if.sv
// Operand/result bundle for the registered 64-bit execute stage.
interface alu_exec_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 4;

    // issue side
    logic                in_valid;
    logic [1:0]          alu_op;
    logic                funct7_b5;
    logic [2:0]          funct3;
    logic                alu_src;
    logic                branch;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic [DATA_W-1:0]   imm;

    // result side
    logic                out_valid;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0]   alu_result;
    logic                zero;
    logic [DATA_W-1:0]   pc_plus4;
    logic [DATA_W-1:0]   branch_target;
    logic                take_branch;
    logic [DATA_W-1:0]   next_pc;

    modport master (
        output in_valid, alu_op, funct7_b5, funct3, alu_src, branch,
               pc, rs1_data, rs2_data, imm,
        input  out_valid, alu_ctrl, alu_result, zero, pc_plus4,
               branch_target, take_branch, next_pc
    );

    modport slave (
        input  in_valid, alu_op, funct7_b5, funct3, alu_src, branch,
               pc, rs1_data, rs2_data, imm,
        output out_valid, alu_ctrl, alu_result, zero, pc_plus4,
               branch_target, take_branch, next_pc
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute stage: ALU-control decode, operand-B mux, 64-bit ALU,
// PC adders and branch/next-PC select, all captured in one output register.
module alu_exec_unit (
    input  logic         clk,
    input  logic         reset_n,
    alu_exec_if.slave    bus
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned SHAM_W = 6;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    alu_ctrl_e           alu_ctrl_c;
    logic [DATA_W-1:0]   op_a_c;
    logic [DATA_W-1:0]   op_b_c;
    logic [SHAM_W-1:0]   shamt_c;
    logic [DATA_W-1:0]   alu_result_c;
    logic                zero_c;
    logic [DATA_W-1:0]   pc_plus4_c;
    logic [DATA_W-1:0]   branch_target_c;
    logic                take_branch_c;
    logic [DATA_W-1:0]   next_pc_c;

    logic                out_valid_d,     out_valid_q;
    logic [CTRL_W-1:0]   alu_ctrl_d,      alu_ctrl_q;
    logic [DATA_W-1:0]   alu_result_d,    alu_result_q;
    logic                zero_d,          zero_q;
    logic [DATA_W-1:0]   pc_plus4_d,      pc_plus4_q;
    logic [DATA_W-1:0]   branch_target_d, branch_target_q;
    logic                take_branch_d,   take_branch_q;
    logic [DATA_W-1:0]   next_pc_d,       next_pc_q;

    // ALU-control decode; I-type arithmetic never subtracts on funct3 000
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        case (bus.alu_op)
            2'b00: alu_ctrl_c = ALU_ADD;
            2'b01: alu_ctrl_c = ALU_SUB;
            default: begin
                case (bus.funct3)
                    3'b000: alu_ctrl_c = (bus.funct7_b5 && (bus.alu_op == 2'b10)) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl_c = ALU_SLL;
                    3'b010: alu_ctrl_c = ALU_SLT;
                    3'b011: alu_ctrl_c = ALU_SLTU;
                    3'b100: alu_ctrl_c = ALU_XOR;
                    3'b101: alu_ctrl_c = bus.funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl_c = ALU_OR;
                    default: alu_ctrl_c = ALU_AND;
                endcase
            end
        endcase
    end

    // Operand select and 64-bit ALU
    always_comb begin
        op_a_c       = bus.rs1_data;
        op_b_c       = bus.alu_src ? bus.imm : bus.rs2_data;
        shamt_c      = op_b_c[SHAM_W-1:0];
        alu_result_c = '0;
        case (alu_ctrl_c)
            ALU_AND:  alu_result_c = op_a_c & op_b_c;
            ALU_OR:   alu_result_c = op_a_c | op_b_c;
            ALU_ADD:  alu_result_c = op_a_c + op_b_c;
            ALU_XOR:  alu_result_c = op_a_c ^ op_b_c;
            ALU_SLL:  alu_result_c = op_a_c << shamt_c;
            ALU_SRL:  alu_result_c = op_a_c >> shamt_c;
            ALU_SUB:  alu_result_c = op_a_c - op_b_c;
            ALU_SLT:  alu_result_c = {{(DATA_W-1){1'b0}}, ($signed(op_a_c) < $signed(op_b_c))};
            ALU_SRA:  alu_result_c = $unsigned($signed(op_a_c) >>> shamt_c);
            ALU_SLTU: alu_result_c = {{(DATA_W-1){1'b0}}, (op_a_c < op_b_c)};
            default:  alu_result_c = '0;
        endcase
        zero_c = (alu_result_c == '0);
    end

    // PC adders and next-PC select
    always_comb begin
        pc_plus4_c      = bus.pc + DATA_W'(4);
        branch_target_c = bus.pc + {bus.imm[DATA_W-2:0], 1'b0};
        take_branch_c   = bus.branch & zero_c;
        next_pc_c       = take_branch_c ? branch_target_c : pc_plus4_c;
    end

    // Next register contents: load on in_valid, otherwise hold data
    always_comb begin
        out_valid_d     = bus.in_valid;
        alu_ctrl_d      = alu_ctrl_q;
        alu_result_d    = alu_result_q;
        zero_d          = zero_q;
        pc_plus4_d      = pc_plus4_q;
        branch_target_d = branch_target_q;
        take_branch_d   = take_branch_q;
        next_pc_d       = next_pc_q;
        if (bus.in_valid) begin
            alu_ctrl_d      = alu_ctrl_c;
            alu_result_d    = alu_result_c;
            zero_d          = zero_c;
            pc_plus4_d      = pc_plus4_c;
            branch_target_d = branch_target_c;
            take_branch_d   = take_branch_c;
            next_pc_d       = next_pc_c;
        end
    end

    // Output register stage; reset clears everything including zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q     <= 1'b0;
            alu_ctrl_q      <= '0;
            alu_result_q    <= '0;
            zero_q          <= 1'b0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
            take_branch_q   <= 1'b0;
            next_pc_q       <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            alu_ctrl_q      <= alu_ctrl_d;
            alu_result_q    <= alu_result_d;
            zero_q          <= zero_d;
            pc_plus4_q      <= pc_plus4_d;
            branch_target_q <= branch_target_d;
            take_branch_q   <= take_branch_d;
            next_pc_q       <= next_pc_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_ctrl      = alu_ctrl_q;
    assign bus.alu_result    = alu_result_q;
    assign bus.zero          = zero_q;
    assign bus.pc_plus4      = pc_plus4_q;
    assign bus.branch_target = branch_target_q;
    assign bus.take_branch   = take_branch_q;
    assign bus.next_pc       = next_pc_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    alu_exec_if bus ();

    alu_exec_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive one operation at the falling edge, then sample 1 time unit after the next rising edge
    task automatic issue(input logic vld, input logic [1:0] op, input logic f7, input logic [2:0] f3,
                         input logic src, input logic br, input logic [63:0] pc_v,
                         input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im);
        @(negedge clk);
        bus.in_valid  = vld;
        bus.alu_op    = op;
        bus.funct7_b5 = f7;
        bus.funct3    = f3;
        bus.alu_src   = src;
        bus.branch    = br;
        bus.pc        = pc_v;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        bus.imm       = im;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct7_b5 = 1'b0; bus.funct3 = 3'b000;
        bus.alu_src = 1'b0; bus.branch = 1'b0; bus.pc = '0; bus.rs1_data = '0;
        bus.rs2_data = '0; bus.imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_zero", 64'(bus.zero), 64'd0);

        @(negedge clk);
        reset_n = 1'b1;

        // Taken branch: loads zero=1/take=1 so the async reset below is visible
        issue(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1, 64'h40, 64'd3, 64'd3, 64'h10);
        chk("br_eq_valid", 64'(bus.out_valid), 64'd1);
        chk("br_eq_ctrl", 64'(bus.alu_ctrl), 64'h6);
        chk("br_eq_zero", 64'(bus.zero), 64'd1);
        chk("br_eq_take", 64'(bus.take_branch), 64'd1);
        chk("br_eq_next_pc", bus.next_pc, 64'h60);
        chk("br_eq_pc_plus4", bus.pc_plus4, 64'h44);
        chk("br_eq_target", bus.branch_target, 64'h60);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_zero", 64'(bus.zero), 64'd0);
        chk("async_rst_take", 64'(bus.take_branch), 64'd0);
        chk("async_rst_next_pc", bus.next_pc, 64'd0);
        chk("async_rst_pc_plus4", bus.pc_plus4, 64'd0);
        chk("async_rst_target", bus.branch_target, 64'd0);
        chk("async_rst_ctrl", 64'(bus.alu_ctrl), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle after release: nothing loads without in_valid
        issue(1'b0, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 64'h40, 64'd7, 64'd5, 64'd0);
        chk("idle_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_result", bus.alu_result, 64'd0);

        // R-type ADD / SUB
        issue(1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 64'd7, 64'd5, 64'd0);
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_ctrl", 64'(bus.alu_ctrl), 64'h2);
        chk("add_result", bus.alu_result, 64'd12);
        chk("add_zero", 64'(bus.zero), 64'd0);
        issue(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 64'h0, 64'd7, 64'd5, 64'd0);
        chk("sub_ctrl", 64'(bus.alu_ctrl), 64'h6);
        chk("sub_result", bus.alu_result, 64'd2);

        // Wrap and signedness
        issue(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 64'h0, 64'd0, 64'd1, 64'd0);
        chk("sub_wrap", bus.alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        chk("slt_ctrl", 64'(bus.alu_ctrl), 64'h7);
        chk("slt_result", bus.alu_result, 64'd1);
        issue(1'b1, 2'b10, 1'b0, 3'b011, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        chk("sltu_ctrl", 64'(bus.alu_ctrl), 64'h9);
        chk("sltu_result", bus.alu_result, 64'd0);
        chk("sltu_zero", 64'(bus.zero), 64'd1);

        // Shifts use only B[5:0]
        issue(1'b1, 2'b10, 1'b0, 3'b101, 1'b0, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'd65, 64'd0);
        chk("srl_ctrl", 64'(bus.alu_ctrl), 64'h5);
        chk("srl_result", bus.alu_result, 64'h4000_0000_0000_0000);
        issue(1'b1, 2'b10, 1'b1, 3'b101, 1'b0, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'd65, 64'd0);
        chk("sra_ctrl", 64'(bus.alu_ctrl), 64'h8);
        chk("sra_result", bus.alu_result, 64'hC000_0000_0000_0000);

        // Hold: in_valid=0 keeps data outputs, drops out_valid
        issue(1'b0, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 64'h0, 64'd1, 64'd1, 64'd0);
        chk("hold_valid", 64'(bus.out_valid), 64'd0);
        chk("hold_result", bus.alu_result, 64'hC000_0000_0000_0000);
        chk("hold_ctrl", 64'(bus.alu_ctrl), 64'h8);

        // Logic ops and SLL
        issue(1'b1, 2'b10, 1'b0, 3'b100, 1'b0, 1'b0, 64'h0, 64'hF0F0, 64'h0FF0, 64'd0);
        chk("xor_result", bus.alu_result, 64'hFF00);
        issue(1'b1, 2'b10, 1'b0, 3'b110, 1'b0, 1'b0, 64'h0, 64'hF0F0, 64'h0FF0, 64'd0);
        chk("or_result", bus.alu_result, 64'hFFF0);
        issue(1'b1, 2'b10, 1'b0, 3'b111, 1'b0, 1'b0, 64'h0, 64'hF0F0, 64'h0FF0, 64'd0);
        chk("and_ctrl", 64'(bus.alu_ctrl), 64'h0);
        chk("and_result", bus.alu_result, 64'h00F0);
        issue(1'b1, 2'b10, 1'b0, 3'b001, 1'b0, 1'b0, 64'h0, 64'hF0F0, 64'h44, 64'd0);
        chk("sll_ctrl", 64'(bus.alu_ctrl), 64'h4);
        chk("sll_result", bus.alu_result, 64'hF_0F00);

        // Load/store address via immediate, distracting rs2
        issue(1'b1, 2'b00, 1'b1, 3'b111, 1'b1, 1'b0, 64'h0, 64'h100, 64'h5, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ld_ctrl", 64'(bus.alu_ctrl), 64'h2);
        chk("ld_result", bus.alu_result, 64'hF8);
        chk("ld_target_wrap", bus.branch_target, 64'hFFFF_FFFF_FFFF_FFF0);
        issue(1'b1, 2'b11, 1'b1, 3'b000, 1'b1, 1'b0, 64'h0, 64'h100, 64'h5, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("itype_add_ctrl", 64'(bus.alu_ctrl), 64'h2);
        chk("itype_add_result", bus.alu_result, 64'hF8);
        issue(1'b1, 2'b11, 1'b1, 3'b101, 1'b1, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'h5, 64'd4);
        chk("itype_sra_ctrl", 64'(bus.alu_ctrl), 64'h8);
        chk("itype_sra_result", bus.alu_result, 64'hF800_0000_0000_0000);

        // Branch not taken, and branch=0 with zero=1
        issue(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1, 64'h40, 64'd3, 64'd4, 64'h10);
        chk("br_ne_take", 64'(bus.take_branch), 64'd0);
        chk("br_ne_next_pc", bus.next_pc, 64'h44);
        chk("br_ne_zero", 64'(bus.zero), 64'd0);
        issue(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 64'h40, 64'd3, 64'd3, 64'h10);
        chk("nobr_zero", 64'(bus.zero), 64'd1);
        chk("nobr_take", 64'(bus.take_branch), 64'd0);
        chk("nobr_next_pc", bus.next_pc, 64'h44);

        // PC+4 wrap-around
        issue(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd1, 64'd0);
        chk("pc4_wrap", bus.pc_plus4, 64'd0);
        chk("pc4_wrap_next", bus.next_pc, 64'd0);

        // Mid-stream reset discards pending result
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.rs1_data = 64'd9;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result", bus.alu_result, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered 64-bit execute stage for the single-cycle RISC-V style CPU datapath. It combines ALU-control decoding, the ALU-source operand mux, a 64-bit ALU with zero flag, and the two PC adders (PC+4 and PC+(imm<<1)). It also makes the branch/next-PC decision. All results are captured in one output register stage; downstream memory and writeback logic consume them.

## Interface
- No parameters; datapath width is fixed at 64 bits and the ALU control code at 4 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  input operands valid this cycle.
- alu_op  in  2  main-control ALUOperation: 00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- funct7_b5  in  1  instruction bit 30.
- funct3  in  3  instruction bits 14:12.
- alu_src  in  1  0 selects rs2_data, 1 selects imm as ALU operand B.
- branch  in  1  main-control Branch.
- pc  in  64  current PC.
- rs1_data, rs2_data  in  64 each  register-file read data.
- imm  in  64  sign-extended immediate.
- out_valid  out  1  registered copy of in_valid.
- alu_ctrl  out  4  decoded ALU operation.
- alu_result  out  64  ALU result.
- zero  out  1  1 when the ALU result is all zeros.
- pc_plus4  out  64  pc + 4.
- branch_target  out  64  pc + (imm << 1).
- take_branch  out  1  branch & zero.
- next_pc  out  64  branch_target if take_branch, else pc_plus4.

## Operation
ALU control codes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0110 SUB
- 0111 SLT
- 1000 SRA
- 1001 SLTU

Decode by alu_op:
- alu_op 00 → ADD, regardless of funct fields.
- alu_op 01 → SUB, regardless of funct fields.
- alu_op 10, by funct3:
  - 000 → SUB if funct7_b5 = 1, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 → SRA if funct7_b5 = 1, else SRL.
  - 110 OR, 111 AND.
- alu_op 11: same as 10, except funct3 000 is always ADD (funct7_b5 ignored). Funct3 101 still uses funct7_b5 to choose SRA/SRL.

ALU rules:
- Operand A = rs1_data; operand B = alu_src ? imm : rs2_data.
- ADD/SUB are modulo 2^64; carry and overflow are discarded.
- Shift amount is B[5:0]. SRA replicates bit 63.
- SLT is a signed comparison and SLTU is unsigned; both produce 64'h1 or 64'h0.

Other outputs:
- zero = (alu_result == 0), evaluated on the same result that is registered.
- pc_plus4 = pc + 4 and branch_target = pc + {imm[62:0], 1'b0}, both modulo 2^64 (wrap-around allowed, no flag).
- take_branch = branch & zero. When branch = 0, next_pc = pc_plus4 regardless of zero.

## Timing
- Decode and arithmetic are combinational from the inputs. Every output is registered: latency is exactly 1 clock.
- Rising edge with in_valid = 1: all outputs load the new results and out_valid ← 1.
- Rising edge with in_valid = 0: out_valid ← 0 and all data outputs hold their previous values.
- reset_n low: immediately, without waiting for clk, all outputs go to 0.
  - out_valid, alu_ctrl, alu_result, pc_plus4, branch_target, next_pc and take_branch are all 0.
  - zero resets to 0, not 1.
- Reset deasserted: the first update occurs on the next rising edge with in_valid = 1.
- Reset asserted mid-stream: the pending result is discarded; nothing is replayed.
- No back-pressure: the stage accepts one operation per cycle, back-to-back, with no stalls.

## Test plan
- Reset: drive reset_n = 0 asynchronously between edges → all outputs read 0 immediately. Release, then apply in_valid = 1 → out_valid = 1 after one edge.
- R-type ADD/SUB: alu_op = 10, funct3 = 000, rs1 = 7, rs2 = 5.
  - funct7_b5 = 0 → alu_ctrl = 0010, alu_result = 12, zero = 0.
  - funct7_b5 = 1 → alu_ctrl = 0110, alu_result = 2.
- Wrap and sign: SUB with rs1 = 0, rs2 = 1 → alu_result = 64'hFFFF_FFFF_FFFF_FFFF.
  - SLT with rs1 = -1, rs2 = 1 → 1.
  - SLTU with the same operands → 0.
- Shifts: rs1 = 64'h8000_0000_0000_0000, B = 65.
  - SRL → 64'h4000_0000_0000_0000 (shift 1).
  - SRA → 64'hC000_0000_0000_0000.
- Load/store address: alu_op = 00, alu_src = 1, rs1 = 0x100, imm = -8 → alu_result = 0xF8.
  - Same inputs with alu_op = 11 and funct3 = 000 → ADD even when funct7_b5 = 1.
- Branch: pc = 0x40, imm = 0x10, alu_op = 01, branch = 1.
  - rs1 = rs2 = 3 → zero = 1, take_branch = 1, next_pc = 0x60, pc_plus4 = 0x44.
  - rs1 = 3, rs2 = 4 → take_branch = 0, next_pc = 0x44.
